// File: rtl/mult_share_arbiter.sv
// mult_share_arbiter: round-robin sharing of one external 4x4 multiplier among four requesters.
// Grant registers the winner's operands, the product is captured one cycle later and returned with done.
module mult_share_arbiter #(
   parameter int NREQ  = 4,
   parameter int CNT_W = 8
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic [3:0]       req,
   input  logic [15:0]      a_bus,
   input  logic [15:0]      b_bus,
   output logic [3:0]       gnt,
   output logic [3:0]       done,
   output logic [7:0]       result,
   output logic [3:0]       mul_in1,
   output logic [3:0]       mul_in2,
   input  logic [7:0]       mul_out,
   output logic             busy,
   output logic [CNT_W-1:0] op_cnt
);
   typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;
   state_t state_q, state_d;
   logic [1:0] last_q, last_d, win_q, win_d, pick, idx;
   logic found;
   logic [3:0] gnt_q, gnt_d, done_q, done_d, in1_q, in1_d, in2_q, in2_d;
   logic [7:0] result_q, result_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   // first pending requester after the previous winner, wrapping
   always_comb begin
      pick = '0;
      idx = '0;
      found = 1'b0;
      for (int k = 1; k <= NREQ; k++) begin
         idx = last_q + 2'(k);
         if (!found && req[idx]) begin
            pick = idx;
            found = 1'b1;
         end
      end
   end
   always_comb begin
      state_d = state_q;
      last_d = last_q;
      win_d = win_q;
      gnt_d = '0;
      done_d = '0;
      result_d = result_q;
      in1_d = in1_q;
      in2_d = in2_q;
      cnt_d = cnt_q;
      case (state_q)
         IDLE: if (found) begin
            win_d = pick;
            in1_d = a_bus[{pick, 2'b00} +: 4];
            in2_d = b_bus[{pick, 2'b00} +: 4];
            gnt_d = 4'b0001 << pick;
            state_d = EXEC;
         end
         EXEC: begin
            result_d = mul_out;
            done_d = 4'b0001 << win_q;
            last_d = win_q;
            cnt_d = cnt_q + 1'b1;
            state_d = DONE;
         end
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q <= IDLE;
         last_q <= 2'd3;
         win_q <= '0;
         gnt_q <= '0;
         done_q <= '0;
         result_q <= '0;
         in1_q <= '0;
         in2_q <= '0;
         cnt_q <= '0;
      end else begin
         state_q <= state_d;
         last_q <= last_d;
         win_q <= win_d;
         gnt_q <= gnt_d;
         done_q <= done_d;
         result_q <= result_d;
         in1_q <= in1_d;
         in2_q <= in2_d;
         cnt_q <= cnt_d;
      end
   end
   assign gnt = gnt_q;
   assign done = done_q;
   assign result = result_q;
   assign mul_in1 = in1_q;
   assign mul_in2 = in2_q;
   assign busy = state_q != IDLE;
   assign op_cnt = cnt_q;
endmodule

// File: doc/mult_share_arbiter.md
Name: mult_share_arbiter

Overview:
- Shares one combinational 4-bit x 4-bit unsigned multiplier (in1, in2 -> 8-bit product) between four requesters.
- Arbitrates round-robin and registers the winner's operands onto the multiplier inputs.
- Captures the product one cycle later and returns it with a one-cycle done pulse to the winner.
- Sits between the requesting datapath units and the shared multiplier instance.

Parameters:
- NREQ, 4, number of requesters (fixed at 4 for this revision; bus widths below assume 4)
- CNT_W, 8, width of the completed-operation counter

Ports:
- CLK  input  1  system clock, rising edge
- RST  input  1  asynchronous, active-high reset
- req  input  4  request per requester; held high until that requester's done pulse
- a_bus  input  16  operand A per requester; requester i on bits [4i+3:4i]
- b_bus  input  16  operand B per requester; requester i on bits [4i+3:4i]
- gnt  output  4  one-hot grant, one-cycle pulse
- done  output  4  one-hot completion, one-cycle pulse
- result  output  8  product of the last completed operation
- mul_in1  output  4  to shared multiplier in1
- mul_in2  output  4  to shared multiplier in2
- mul_out  input  8  from shared multiplier product
- busy  output  1  high when state != IDLE
- op_cnt  output  CNT_W  number of completed operations

Behaviour:
- Reset (async, RST=1) forces:
  - state=IDLE; gnt=0, done=0, result=0, mul_in1=0, mul_in2=0, op_cnt=0.
  - last=3, so requester 0 has top priority after reset.
- Reset mid-operation aborts the operation: no done pulse, and result is not updated.
- States are IDLE, EXEC and DONE.
- IDLE:
  - Requests are sampled only in this state.
  - If req != 0 at an edge: choose the winner w by scanning from (last+1) mod 4 upward with wrap.
  - On that edge: mul_in1 <= a_bus[w], mul_in2 <= b_bus[w], gnt <= onehot(w), latch w, state <= EXEC.
  - If req == 0: hold all outputs, except gnt and done, which stay 0.
- EXEC (one cycle):
  - gnt is high for this cycle only, and the multiplier inputs are stable.
  - On the next edge: result <= mul_out, done <= onehot(w), gnt <= 0, last <= w, op_cnt <= op_cnt+1 (wraps modulo 2^CNT_W), state <= DONE.
- DONE (one cycle):
  - done is high and result is valid.
  - On the next edge: done <= 0, state <= IDLE.
- Latency: req sampled at edge E0; gnt high E0..E1; done and result valid E1..E2; the next grant edge is no earlier than E3.
- Throughput: one operation per 3 cycles under continuous requests.
- Operands are captured only at the grant edge. Changes to a_bus/b_bus afterwards are ignored for that operation.
- A requester that drops req during EXEC or DONE still receives its done pulse and result.
- A requester that keeps req high after its done re-enters arbitration in IDLE, but only behind the other pending requesters (round-robin).
- Simultaneous requests: exactly one grant; the others wait. No requester starves: the maximum wait is 3 grants.
- mul_in1/mul_in2 hold their last operands while idle.
- result holds its last value until the next capture.
- Product width: full 8-bit unsigned. 15*15=225 fits without truncation.
- gnt and done are never both nonzero in the same cycle.
- At most one bit of gnt or done is set at any time.

Test Plan:
- Reset then single request:
  - Stimulus: req=0001, a0=3, b0=5.
  - Required: gnt=0001 one cycle after the sampling edge; next cycle done=0001 with result=15; op_cnt=1; busy high for 2 cycles.
- Max operands:
  - Stimulus: req=0100, a2=15, b2=15.
  - Required: result=225 (8'hE1) with done=0100.
- All four requesting continuously, with a_i=i+1 and b_i=2:
  - Required grant order 0,1,2,3,0: results 2, 4, 6, 8, 2; one grant every 3 cycles; op_cnt increments each done.
- Operand change after grant:
  - Stimulus: a1=7, b1=7 at the grant edge, then change to a1=1 during EXEC.
  - Required: result=49.
- Reset asserted asynchronously during EXEC, mid-cycle:
  - Required: all outputs 0 immediately; no done pulse afterwards; next request from requester 0 is granted first.
- Counter wrap:
  - Stimulus: 256 operations.
  - Required: op_cnt returns to 0; a reference model comparing every result against a*b over 20+ random operand pairs shows 0 mismatches.
